// File: rtl/hmc6502_pkg.sv
// hmc6502_pkg: opcodes, FSM states, addressing modes and fixed addresses
// shared by the 6502-subset CPU and its memory.
package hmc6502_pkg;
    localparam logic [7:0] OP_LDA_IMM = 8'hA9, OP_LDA_ZP = 8'hA5, OP_LDA_ABS = 8'hAD;
    localparam logic [7:0] OP_LDX_IMM = 8'hA2, OP_LDX_ZP = 8'hA6;
    localparam logic [7:0] OP_LDY_IMM = 8'hA0;
    localparam logic [7:0] OP_STA_ZP  = 8'h85, OP_STA_ABS = 8'h8D;
    localparam logic [7:0] OP_STX_ZP  = 8'h86;
    localparam logic [7:0] OP_STY_ZP  = 8'h84;
    localparam logic [7:0] OP_AND_IMM = 8'h29, OP_AND_ZP = 8'h25, OP_AND_ABS = 8'h2D;
    localparam logic [7:0] OP_ORA_IMM = 8'h09, OP_ORA_ZP = 8'h05, OP_ORA_ABS = 8'h0D;
    localparam logic [7:0] OP_EOR_IMM = 8'h49, OP_EOR_ZP = 8'h45, OP_EOR_ABS = 8'h4D;
    localparam logic [7:0] OP_JMP_ABS = 8'h4C;
    localparam logic [7:0] OP_NOP     = 8'hEA;
    localparam logic [7:0] OP_BRK     = 8'h00;

    localparam logic [15:0] RESET_VEC     = 16'hFFFC;
    localparam logic [15:0] ROM_BASE_ADDR = 16'hF000;

    typedef enum logic [2:0] {VEC_LO, VEC_HI, FETCH, OPER_LO, OPER_HI, EXEC, HALT} state_t;
    typedef enum logic [1:0] {AM_IMP, AM_IMM, AM_ZP, AM_ABS} mode_t;

    // Unknown opcodes fall into AM_IMP and therefore run as 1-byte NOPs.
    function automatic mode_t mode_of(input logic [7:0] op);
        case (op)
            OP_LDA_IMM, OP_LDX_IMM, OP_LDY_IMM, OP_AND_IMM, OP_ORA_IMM, OP_EOR_IMM:
                return AM_IMM;
            OP_LDA_ZP, OP_LDX_ZP, OP_STA_ZP, OP_STX_ZP, OP_STY_ZP, OP_AND_ZP, OP_ORA_ZP, OP_EOR_ZP:
                return AM_ZP;
            OP_LDA_ABS, OP_STA_ABS, OP_AND_ABS, OP_ORA_ABS, OP_EOR_ABS, OP_JMP_ABS:
                return AM_ABS;
            default:
                return AM_IMP;
        endcase
    endfunction
endpackage

// File: rtl/hmc6502_memory.sv
// memory: RAM at $0000 upward and ROM at ROM_BASE; combinational read,
// write committed on the clock edge, unmapped space reads $00.
module memory
    import hmc6502_pkg::*;
#(
    parameter int          RAM_WORDS = 1024,
    parameter int          ROM_WORDS = 4096,
    parameter logic [15:0] ROM_BASE  = ROM_BASE_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic        we,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata
);
    localparam int RAW = $clog2(RAM_WORDS);
    localparam int ROW = $clog2(ROM_WORDS);

    logic [7:0] ROM [0:ROM_WORDS-1];
    logic [7:0] RAM [0:RAM_WORDS-1];
    logic in_ram, in_rom;

    assign in_ram = addr < 16'(RAM_WORDS);
    assign in_rom = addr >= ROM_BASE;
    assign rdata  = in_ram ? RAM[addr[RAW-1:0]] : in_rom ? ROM[addr[ROW-1:0]] : 8'h00;

    // A write racing the reset edge is dropped; contents are never reset.
    always_ff @(posedge clk)
        if (we && in_ram && !rst) RAM[addr[RAW-1:0]] <= wdata;
endmodule

// File: rtl/top.sv
// top: multicycle 6502-subset CPU (loads, stores, AND/ORA/EOR, JMP, NOP, BRK)
// wired to the memory block; ph2 is accepted but unused.
module top
    import hmc6502_pkg::*;
#(
    parameter int          RAM_WORDS = 1024,
    parameter int          ROM_WORDS = 4096,
    parameter logic [15:0] ROM_BASE  = ROM_BASE_ADDR
) (
    input logic ph1,
    input logic ph2,
    input logic reset
);
    state_t      state;
    mode_t       mode;
    logic [15:0] pc, ea, addr;
    logic [7:0]  a, x, y, ir, rdata, wdata, res;
    logic        n, z, we, ld_a, ld_x, ld_y, unused_ph2;

    assign unused_ph2 = ph2;
    assign mode       = mode_of(ir);

    memory #(.RAM_WORDS(RAM_WORDS), .ROM_WORDS(ROM_WORDS), .ROM_BASE(ROM_BASE)) mem (
        .clk(ph1), .rst(reset), .addr(addr), .we(we), .wdata(wdata), .rdata(rdata)
    );

    // Operand comes from PC for immediates and from ea for zp/abs in EXEC.
    always_comb begin
        addr  = state == VEC_LO ? RESET_VEC :
                state == VEC_HI ? RESET_VEC + 16'd1 :
                (state == EXEC && (mode == AM_ZP || mode == AM_ABS)) ? ea : pc;
        we    = state == EXEC && (ir inside {OP_STA_ZP, OP_STA_ABS, OP_STX_ZP, OP_STY_ZP});
        wdata = ir == OP_STX_ZP ? x : ir == OP_STY_ZP ? y : a;
        res   = ir inside {OP_AND_IMM, OP_AND_ZP, OP_AND_ABS} ? a & rdata :
                ir inside {OP_ORA_IMM, OP_ORA_ZP, OP_ORA_ABS} ? a | rdata :
                ir inside {OP_EOR_IMM, OP_EOR_ZP, OP_EOR_ABS} ? a ^ rdata : rdata;
        ld_a  = ir inside {OP_LDA_IMM, OP_LDA_ZP, OP_LDA_ABS, OP_AND_IMM, OP_AND_ZP, OP_AND_ABS,
                           OP_ORA_IMM, OP_ORA_ZP, OP_ORA_ABS, OP_EOR_IMM, OP_EOR_ZP, OP_EOR_ABS};
        ld_x  = ir inside {OP_LDX_IMM, OP_LDX_ZP};
        ld_y  = ir == OP_LDY_IMM;
    end

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            state <= VEC_LO;
            pc    <= RESET_VEC;
            ea    <= 16'h0000;
            ir    <= 8'h00;
            a     <= 8'h00;
            x     <= 8'h00;
            y     <= 8'h00;
            n     <= 1'b0;
            z     <= 1'b0;
        end else begin
            case (state)
                VEC_LO: begin
                    pc[7:0] <= rdata;
                    state   <= VEC_HI;
                end
                VEC_HI: begin
                    pc[15:8] <= rdata;
                    state    <= FETCH;
                end
                FETCH: begin
                    ir    <= rdata;
                    pc    <= pc + 16'd1;
                    state <= rdata == OP_BRK ? HALT :
                             mode_of(rdata) inside {AM_ZP, AM_ABS} ? OPER_LO : EXEC;
                end
                OPER_LO: begin
                    ea    <= {8'h00, rdata};
                    pc    <= pc + 16'd1;
                    state <= mode == AM_ABS ? OPER_HI : EXEC;
                end
                OPER_HI: begin
                    ea[15:8] <= rdata;
                    pc       <= ir == OP_JMP_ABS ? {rdata, ea[7:0]} : pc + 16'd1;
                    state    <= ir == OP_JMP_ABS ? FETCH : EXEC;
                end
                EXEC: begin
                    if (mode == AM_IMM) pc <= pc + 16'd1;
                    if (ld_a) a <= res;
                    if (ld_x) x <= res;
                    if (ld_y) y <= res;
                    if (ld_a || ld_x || ld_y) begin
                        n <= res[7];
                        z <= res == 8'h00;
                    end
                    state <= FETCH;
                end
                default: state <= HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_top.sv
// tb_top: scoreboard bench; an instruction-level model predicts register
// snapshots at each opcode fetch and every bus write, a monitor compares them.
module tb_top;
    import hmc6502_pkg::*;

    typedef struct packed {
        logic [15:0] pc;
        logic [7:0]  a, x, y;
        logic        n, z;
    } snap_t;

    logic ph1 = 1'b0, reset = 1'b1, ph2;
    assign ph2 = ~ph1;
    always #5 ph1 = ~ph1;

    top dut (.ph1(ph1), .ph2(ph2), .reset(reset));

    int          checks = 0, errors = 0, exp_cycles;
    bit          active = 1'b0;
    snap_t       sq[$];
    logic [23:0] wq[$];
    snap_t       ms;
    logic [23:0] mw;
    logic [7:0]  m_rom [0:4095];
    logic [7:0]  m_ram [0:1023];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] m_rd(input logic [15:0] ad);
        return ad < 16'd1024 ? m_ram[ad[9:0]] : ad >= 16'hF000 ? m_rom[ad[11:0]] : 8'h00;
    endfunction

    task automatic m_wr(input logic [15:0] ad, input logic [7:0] d);
        wq.push_back({ad, d});
        if (ad < 16'd1024) m_ram[ad[9:0]] = d;
    endtask

    // Instruction-at-a-time interpreter of the ISA as specified.
    task automatic model_run();
        logic [15:0] pc, ea;
        logic [7:0]  a = 0, x = 0, y = 0, op, v;
        logic        n = 0, z = 0;
        sq.delete();
        wq.delete();
        pc = {m_rd(16'hFFFD), m_rd(16'hFFFC)};
        exp_cycles = 2;
        for (int g = 0; g < 2000; g++) begin
            sq.push_back('{pc, a, x, y, n, z});
            op = m_rd(pc);
            pc = pc + 16'd1;
            if (op == 8'h00) begin
                exp_cycles += 1;
                break;
            end
            ea = pc;
            if (op inside {8'hA9, 8'hA2, 8'hA0, 8'h29, 8'h09, 8'h49}) begin
                pc = pc + 16'd1;
                exp_cycles += 2;
            end else if (op inside {8'hA5, 8'hA6, 8'h85, 8'h86, 8'h84, 8'h25, 8'h05, 8'h45}) begin
                ea = {8'h00, m_rd(pc)};
                pc = pc + 16'd1;
                exp_cycles += 3;
            end else if (op inside {8'hAD, 8'h8D, 8'h2D, 8'h0D, 8'h4D, 8'h4C}) begin
                ea = {m_rd(pc + 16'd1), m_rd(pc)};
                pc = pc + 16'd2;
                exp_cycles += op == 8'h4C ? 3 : 4;
            end else exp_cycles += 2;
            v = m_rd(ea);
            case (op)
                8'hA9, 8'hA5, 8'hAD: a = v;
                8'hA2, 8'hA6:        x = v;
                8'hA0:               y = v;
                8'h29, 8'h25, 8'h2D: a = a & v;
                8'h09, 8'h05, 8'h0D: a = a | v;
                8'h49, 8'h45, 8'h4D: a = a ^ v;
                8'h85, 8'h8D:        m_wr(ea, a);
                8'h86:               m_wr(ea, x);
                8'h84:               m_wr(ea, y);
                8'h4C:               pc = ea;
                default: ;
            endcase
            if (op inside {8'hA9, 8'hA5, 8'hAD, 8'h29, 8'h25, 8'h2D, 8'h09, 8'h05, 8'h0D,
                           8'h49, 8'h45, 8'h4D}) {n, z} = {a[7], a == 8'h00};
            if (op inside {8'hA2, 8'hA6}) {n, z} = {x[7], x == 8'h00};
            if (op == 8'hA0) {n, z} = {y[7], y == 8'h00};
        end
    endtask

    always @(negedge ph1) begin
        if (active && !reset) begin
            if (dut.state == FETCH) begin
                if (sq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fetch: unexpected fetch at pc %h", dut.pc);
                end else begin
                    ms = sq.pop_front();
                    chk("fetch snapshot", 64'({dut.pc, dut.a, dut.x, dut.y, dut.n, dut.z}), 64'(ms));
                end
            end
            if (dut.we) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL write: unexpected write %h<=%h", dut.addr, dut.wdata);
                end else begin
                    mw = wq.pop_front();
                    chk("bus write", 64'({dut.addr, dut.wdata}), 64'(mw));
                end
            end
        end
    end

    task automatic init_mem();
        for (int i = 0; i < 4096; i++) m_rom[i] = 8'($urandom);
        for (int i = 0; i < 1024; i++) m_ram[i] = 8'($urandom);
        m_rom[12'hFFC] = 8'h00;
        m_rom[12'hFFD] = 8'hF0;
    endtask

    task automatic put(input logic [7:0] b[$], input int off);
        foreach (b[i]) m_rom[off + i] = b[i];
    endtask

    task automatic load_dut();
        for (int i = 0; i < 4096; i++) dut.mem.ROM[i] = m_rom[i];
        for (int i = 0; i < 1024; i++) dut.mem.RAM[i] = m_ram[i];
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        @(negedge ph1);
        @(negedge ph1);
        chk({tag, " reset state"}, 64'({dut.a, dut.x, dut.y, dut.n, dut.z, dut.pc, dut.state}),
            64'({24'h0, 2'b00, 16'hFFFC, VEC_LO}));
    endtask

    task automatic run_prog(input string tag, input int budget);
        int nbad = 0, cyc = 0;
        bit seen = 0;
        load_dut();
        model_run();
        do_reset(tag);
        active = 1'b1;
        reset  = 1'b0;
        while (cyc < budget && dut.state != HALT) begin
            @(posedge ph1);
            cyc++;
            @(negedge ph1);
            if (!seen && dut.state == FETCH) begin
                seen = 1;
                chk({tag, " vector fetch"}, 64'({cyc <= 3, dut.addr}),
                    64'({1'b1, m_rom[12'hFFD], m_rom[12'hFFC]}));
            end
        end
        active = 1'b0;
        chk({tag, " cycles to halt"}, 64'(cyc), 64'(exp_cycles));
        chk({tag, " pending expectations"}, 64'(sq.size() + wq.size()), 64'(0));
        checks++;
        for (int i = 0; i < 1024; i++)
            if (dut.mem.RAM[i] !== m_ram[i]) begin
                if (nbad == 0) $display("FAIL %s ram[%0d]: got %h expected %h", tag, i, dut.mem.RAM[i], m_ram[i]);
                nbad++;
            end
        if (nbad != 0) errors++;
    endtask

    task automatic gen_random(input int count);
        logic [7:0] b[$];
        logic [7:0] imm[$] = '{8'hA9, 8'hA2, 8'hA0, 8'h29, 8'h09, 8'h49};
        logic [7:0] zp[$]  = '{8'hA5, 8'hA6, 8'h85, 8'h86, 8'h84, 8'h25, 8'h05, 8'h45};
        logic [7:0] ab[$]  = '{8'hAD, 8'h8D, 8'h2D, 8'h0D, 8'h4D};
        logic [7:0] misc[$] = '{8'hEA, 8'h02, 8'h8A, 8'hFF, 8'hE8};
        logic [15:0] ad;
        for (int i = 0; i < count; i++) begin
            case ($urandom_range(0, 3))
                0: b = {b, imm[$urandom_range(0, 5)], 8'($urandom)};
                1: b = {b, zp[$urandom_range(0, 7)], 8'($urandom)};
                2: begin
                    case ($urandom_range(0, 3))
                        0, 1:    ad = 16'($urandom_range(0, 1023));
                        2:       ad = 16'($urandom_range(16'hF000, 16'hFFFF));
                        default: ad = 16'($urandom_range(16'h0400, 16'hEFFF));
                    endcase
                    b = {b, ab[$urandom_range(0, 4)], ad[7:0], ad[15:8]};
                end
                default: b.push_back(misc[$urandom_range(0, 4)]);
            endcase
        end
        b.push_back(8'h00);
        put(b, 0);
    endtask

    initial begin
        int k;
        logic [7:0] jp[$];

        init_mem();
        put('{8'hA9, 8'h55, 8'h29, 8'hF0, 8'h09, 8'h0A, 8'h49, 8'hFF, 8'h85, 8'hA9, 8'h00}, 0);
        run_prog("logic", 400);
        chk("logic A", 64'(dut.a), 64'(8'hA5));
        chk("logic ram[169]", 64'(dut.mem.RAM[169]), 64'(8'hA5));
        chk("logic halted", 64'(dut.state), 64'(HALT));

        init_mem();
        put('{8'hA9, 8'h0F, 8'h29, 8'hFF, 8'h09, 8'hF0, 8'h49, 8'h55, 8'h85, 8'hA9, 8'h00}, 0);
        run_prog("regress", 345);
        chk("regress ram[169]", 64'(dut.mem.RAM[169]), 64'(8'hAA));

        init_mem();
        put('{8'hA9, 8'h00, 8'h85, 8'h20, 8'hA9, 8'h80, 8'h85, 8'h21, 8'h00}, 0);
        run_prog("flags", 400);
        chk("flags final NZ", 64'({dut.n, dut.z}), 64'(2'b10));

        init_mem();
        jp = '{8'hA2, 8'h3C, 8'hA0, 8'hA5, 8'h86, 8'h10, 8'h84, 8'h11, 8'hAD, 8'h10, 8'h00,
               8'h45, 8'h11, 8'h85, 8'h12, 8'h4C, 8'h20, 8'hF0};
        while (jp.size() < 32) jp.push_back(8'h00);
        jp = {jp, 8'h09, 8'h40, 8'h8D, 8'h00, 8'h02, 8'h00};
        put(jp, 0);
        run_prog("modes", 400);
        chk("modes ram[10..12]", 64'({dut.mem.RAM[16], dut.mem.RAM[17], dut.mem.RAM[18]}), 64'(24'h3CA599));
        chk("modes jmp ram[200]", 64'(dut.mem.RAM[512]), 64'(8'hD9));
        chk("modes A", 64'(dut.a), 64'(8'hD9));

        for (int t = 0; t < 20; t++) begin
            init_mem();
            gen_random(40);
            run_prog($sformatf("rand%0d", t), 1000);
        end

        init_mem();
        put('{8'hA9, 8'h77, 8'h8D, 8'h23, 8'h01, 8'h00}, 0);
        m_ram[12'h123] = 8'h3C;
        load_dut();
        do_reset("areset");
        reset = 1'b0;
        k = 0;
        while (k < 20 && !(dut.state == OPER_HI && dut.ir == 8'h8D)) begin
            @(negedge ph1);
            k++;
        end
        chk("areset reached OPER_HI", 64'(k < 20), 64'(1));
        reset = 1'b1;
        #1;
        chk("areset immediate", 64'({dut.state, dut.pc}), 64'({VEC_LO, 16'hFFFC}));
        @(negedge ph1);
        @(negedge ph1);
        chk("areset ram untouched", 64'(dut.mem.RAM[12'h123]), 64'(8'h3C));
        reset = 1'b0;
        k = 0;
        while (k < 3 && dut.state != FETCH) begin
            @(negedge ph1);
            k++;
        end
        chk("areset refetch", 64'({dut.state, dut.addr}), 64'({FETCH, 16'hF000}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
